// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IMEM request handshake with skid buffer
// for responses that land during a stall, stale-response discard after redirects, and the IF/ID register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             PC_stall,
  input  logic             IFID_stall,
  input  logic             IFID_flush,
  input  logic             jump,
  input  logic [31:0]      npc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      IFID_pc,
  output logic [31:0]      IFID_inst,
  output logic             IFID_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s, addr_r, addr_s, skid_r, skid_s;
  logic [31:0] ifid_pc_r, ifid_pc_s, ifid_inst_r, ifid_inst_s;
  logic        ifid_valid_r, ifid_valid_s;
  logic        req_en_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic        stall_s, redir_s, squash_s, ready_s;
  logic [31:0] pc_inc_s;

  assign stall_s  = PC_stall | IFID_stall;
  assign redir_s  = jump & ~stall_s;
  assign squash_s = IFID_flush & ~stall_s & ~jump;
  assign pc_inc_s = pc_r + 32'd4;
  // req_en_r keeps the request low for the first cycle after reset so a stale response is ignored
  assign imem_req = rstn & req_en_r & (state_r != S_HOLD);
  assign ready_s  = imem_ready & imem_req;

  assign pc         = pc_r;
  assign imem_addr  = addr_r;
  assign IFID_pc    = ifid_pc_r;
  assign IFID_inst  = ifid_inst_r;
  assign IFID_valid = ifid_valid_r;
  assign stall_cnt  = stall_cnt_r;
  assign flush_cnt  = flush_cnt_r;

  // Next-state, PC, skid buffer and IF/ID selection
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    skid_s       = skid_r;
    ifid_pc_s    = ifid_pc_r;
    ifid_inst_s  = ifid_inst_r;
    ifid_valid_s = ifid_valid_r;
    case (state_r)
      S_FETCH: begin
        if (stall_s) begin
          if (ready_s) begin
            skid_s  = imem_rdata;
            state_s = S_HOLD;
          end else begin
            state_s = S_FETCH;
          end
        end else if (redir_s) begin
          ifid_inst_s  = NOP_INSTR;
          ifid_valid_s = 1'b0;
          pc_s         = npc;
          state_s      = ready_s ? S_FETCH : S_DROP;
        end else if (ready_s) begin
          pc_s         = pc_inc_s;
          ifid_pc_s    = squash_s ? ifid_pc_r : pc_r;
          ifid_inst_s  = squash_s ? NOP_INSTR : imem_rdata;
          ifid_valid_s = ~squash_s;
        end else begin
          ifid_inst_s  = NOP_INSTR;
          ifid_valid_s = 1'b0;
        end
      end
      S_HOLD: begin
        if (stall_s) begin
          state_s = S_HOLD;
        end else if (redir_s) begin
          ifid_inst_s  = NOP_INSTR;
          ifid_valid_s = 1'b0;
          pc_s         = npc;
          state_s      = S_FETCH;
        end else begin
          pc_s         = pc_inc_s;
          ifid_pc_s    = squash_s ? ifid_pc_r : pc_r;
          ifid_inst_s  = squash_s ? NOP_INSTR : skid_r;
          ifid_valid_s = ~squash_s;
          state_s      = S_FETCH;
        end
      end
      S_DROP: begin
        // The stale response is discarded even under stall; redirects only retarget pc
        state_s = ready_s ? S_FETCH : S_DROP;
        pc_s    = redir_s ? npc : pc_r;
        if (!stall_s) begin
          ifid_inst_s  = NOP_INSTR;
          ifid_valid_s = 1'b0;
        end else begin
          ifid_valid_s = ifid_valid_r;
        end
      end
      default: begin
        state_s = S_FETCH;
      end
    endcase
    addr_s = (state_s == S_DROP) ? addr_r : pc_s;
  end

  // State, PC, IF/ID and counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= S_FETCH;
      pc_r         <= RESET_PC;
      addr_r       <= RESET_PC;
      skid_r       <= 32'h0000_0000;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_inst_r  <= NOP_INSTR;
      ifid_valid_r <= 1'b0;
      req_en_r     <= 1'b0;
      stall_cnt_r  <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      addr_r       <= addr_s;
      skid_r       <= skid_s;
      ifid_pc_r    <= ifid_pc_s;
      ifid_inst_r  <= ifid_inst_s;
      ifid_valid_r <= ifid_valid_s;
      req_en_r     <= 1'b1;
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (redir_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a latency-configurable IMEM model pushes expected IF/ID
// contents into a scoreboard queue; directed sequences cover stall, redirect, wrap and reset.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn, PC_stall, IFID_stall, IFID_flush, jump;
  logic [31:0] npc, imem_addr, imem_rdata, pc, IFID_pc, IFID_inst;
  logic        imem_req, imem_ready, IFID_valid;
  logic [31:0] stall_cnt, flush_cnt;

  if_fetch_stage dut (
    .clk(clk), .rstn(rstn), .PC_stall(PC_stall), .IFID_stall(IFID_stall),
    .IFID_flush(IFID_flush), .jump(jump), .npc(npc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .IFID_pc(IFID_pc), .IFID_inst(IFID_inst),
    .IFID_valid(IFID_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0, n_fail = 0;
  int          lat, wait_cnt;
  bit          sb_on, push_en, drop_pend;
  logic [31:0] exp_pc, drop_addr;
  logic [63:0] last_exp, e;
  logic [63:0] sb_q[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hDEAD_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // One clock: IMEM model answers, scoreboard pops on valid IF/ID output
  task automatic tick();
    if (imem_req) begin
      if (drop_pend) check_eq("drop_addr", 64'(imem_addr), 64'(drop_addr));
      else check_eq("fetch_addr", 64'(imem_addr), 64'(exp_pc));
      if (wait_cnt >= lat - 1) begin
        imem_ready = 1'b1;
        imem_rdata = instr_of(imem_addr);
        wait_cnt   = 0;
        if (drop_pend) drop_pend = 1'b0;
        else if (push_en) begin
          sb_q.push_back({exp_pc, instr_of(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end
      end else begin
        imem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ready = 1'b0;
      wait_cnt   = 0;
    end
    @(posedge clk); #1;
    imem_ready = 1'b0;
    if (sb_on) begin
      if (IFID_valid) begin
        if (sb_q.size() == 0) check_eq("sb_underflow", 64'd1, 64'd0);
        else begin
          e = sb_q.pop_front();
          last_exp = e;
          check_eq("ifid", {IFID_pc, IFID_inst}, e);
        end
      end else begin
        check_eq("bubble", 64'(IFID_inst), 64'(NOP));
      end
      check_eq("pc", 64'(pc), 64'(exp_pc));
    end
  endtask

  initial begin
    rstn = 1'b0; PC_stall = 1'b0; IFID_stall = 1'b0; IFID_flush = 1'b0; jump = 1'b0;
    npc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    lat = 1; wait_cnt = 0; sb_on = 1'b1; push_en = 1'b1; drop_pend = 1'b0;
    exp_pc = 32'h0; drop_addr = 32'h0; last_exp = 64'h0;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("rst_pc", 64'(pc), 64'h0);
    check_eq("rst_req", 64'(imem_req), 64'h0);
    check_eq("rst_valid", 64'(IFID_valid), 64'h0);
    check_eq("rst_inst", 64'(IFID_inst), 64'(NOP));
    check_eq("rst_ifid_pc", 64'(IFID_pc), 64'h0);
    check_eq("rst_cnts", {stall_cnt, flush_cnt}, 64'h0);
    rstn = 1'b1;

    // Zero-wait stream: first valid on the second cycle after release
    tick();
    check_eq("first_invalid", 64'(IFID_valid), 64'h0);
    tick();
    check_eq("second_valid", 64'(IFID_valid), 64'h1);
    repeat (4) tick();

    // Three-cycle IMEM: two bubbles between instructions
    lat = 3;
    repeat (9) tick();
    check_eq("t2_pc", 64'(exp_pc), 64'h20);

    // Redirect to 0x100 while the 0x20 fetch is outstanding
    drop_pend = 1'b1; drop_addr = exp_pc; exp_pc = 32'h100;
    jump = 1'b1; npc = 32'h100;
    tick();
    jump = 1'b0;
    repeat (5) tick();
    check_eq("t4_flush_cnt", 64'(flush_cnt), 64'd1);

    // Two-cycle stall with the response arriving in the first stall cycle
    lat = 1;
    PC_stall = 1'b1; sb_on = 1'b0; push_en = 1'b0;
    tick();
    check_eq("hold_req", 64'(imem_req), 64'h0);
    check_eq("hold_pc", 64'(pc), 64'(exp_pc));
    tick();
    check_eq("hold_req2", 64'(imem_req), 64'h0);
    PC_stall = 1'b0;
    sb_q.push_back({exp_pc, instr_of(exp_pc)});
    exp_pc = exp_pc + 32'd4;
    sb_on = 1'b1; push_en = 1'b1;
    tick();
    check_eq("t3_stall_cnt", 64'(stall_cnt), 64'd2);
    repeat (2) tick();

    // Jump together with IFID_stall is ignored
    IFID_stall = 1'b1; jump = 1'b1; npc = 32'h200; sb_on = 1'b0; push_en = 1'b0;
    tick();
    check_eq("t5_pc", 64'(pc), 64'(exp_pc));
    check_eq("t5_ifid", {IFID_pc, IFID_inst}, last_exp);
    check_eq("t5_flush_cnt", 64'(flush_cnt), 64'd1);
    check_eq("t5_stall_cnt", 64'(stall_cnt), 64'd3);
    IFID_stall = 1'b0; jump = 1'b0;
    sb_q.push_back({exp_pc, instr_of(exp_pc)});
    exp_pc = exp_pc + 32'd4;
    sb_on = 1'b1; push_en = 1'b1;
    repeat (2) tick();

    // Redirect with a same-cycle response, then sequential wrap past 0xFFFF_FFFC
    jump = 1'b1; npc = 32'hFFFF_FFF8; sb_on = 1'b0; push_en = 1'b0;
    tick();
    jump = 1'b0;
    check_eq("t6_jump_pc", 64'(pc), 64'hFFFF_FFF8);
    check_eq("t6_jump_bubble", 64'(IFID_valid), 64'h0);
    exp_pc = 32'hFFFF_FFF8; sb_on = 1'b1; push_en = 1'b1;
    repeat (2) tick();
    check_eq("wrap_pc", 64'(pc), 64'h0);
    tick();

    // Reset while discarding a stale response
    lat = 3;
    drop_pend = 1'b1; drop_addr = exp_pc; exp_pc = 32'h300; sb_on = 1'b0;
    jump = 1'b1; npc = 32'h300;
    tick();
    jump = 1'b0;
    check_eq("drop_pc", 64'(pc), 64'h300);
    rstn = 1'b0; #1;
    check_eq("rst_req_comb", 64'(imem_req), 64'h0);
    @(posedge clk); #1;
    check_eq("rst2_pc", 64'(pc), 64'h0);
    check_eq("rst2_addr", 64'(imem_addr), 64'h0);
    check_eq("rst2_cnts", {stall_cnt, flush_cnt}, 64'h0);
    rstn = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0; #1;
    check_eq("post_rst_req", 64'(imem_req), 64'h0);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    check_eq("stale_valid", 64'(IFID_valid), 64'h0);
    check_eq("stale_inst", 64'(IFID_inst), 64'(NOP));
    check_eq("stale_pc", 64'(pc), 64'h0);
    drop_pend = 1'b0; wait_cnt = 0; lat = 1; exp_pc = 32'h0;
    sb_q.delete(); sb_on = 1'b1; push_en = 1'b1;
    repeat (3) tick();

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
